regfile_sb: RTL and testbench

REGFILE_SB -- requirements
Module: regfile_sb

---
 rtl/regfile_sb_if.sv | 29 ++
 rtl/regfile_sb.sv | 63 ++++++
 tb/tb_regfile_sb.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_sb_if.sv
// Register-file bus: read ports, write port, issue (set) strobe and flush.
// The master drives addresses and strobes; the slave returns read data and busy flags.
interface regfile_sb_if #(
  parameter int CPU_WIDTH = 32,
  parameter int REG_QUAN  = 32,
  parameter int RD_PORTS  = 2
);
  localparam int AW = $clog2(REG_QUAN);

  logic [RD_PORTS*AW-1:0]        rd_addr;
  logic [RD_PORTS*CPU_WIDTH-1:0] rd_data;
  logic [RD_PORTS-1:0]           rd_busy;
  logic                          wr_en;
  logic [AW-1:0]                 wr_addr;
  logic [CPU_WIDTH-1:0]          wr_data;
  logic                          set_en;
  logic [AW-1:0]                 set_addr;
  logic                          flush;

  modport master (
    output rd_addr, wr_en, wr_addr, wr_data, set_en, set_addr, flush,
    input  rd_data, rd_busy
  );

  modport slave (
    input  rd_addr, wr_en, wr_addr, wr_data, set_en, set_addr, flush,
    output rd_data, rd_busy
  );
endinterface

// File: rtl/regfile_sb.sv
// Multi-port register file with per-register busy scoreboard.
// x0 is hardwired to zero and never busy; optional write-to-read forwarding.
module regfile_sb #(
  parameter int CPU_WIDTH = 32,
  parameter int REG_QUAN  = 32,
  parameter int RD_PORTS  = 2,
  parameter int BYPASS    = 1
) (
  input  logic        clk,
  input  logic        rstn,
  regfile_sb_if.slave bus
);
  localparam int AW = $clog2(REG_QUAN);

  logic [CPU_WIDTH-1:0] regs_q [REG_QUAN];
  logic [CPU_WIDTH-1:0] regs_d [REG_QUAN];
  logic [REG_QUAN-1:0]  busy_q;
  logic [REG_QUAN-1:0]  busy_d;
  logic                 wr_hit;
  logic                 set_hit;

  assign wr_hit  = bus.wr_en  && (bus.wr_addr  != '0);
  assign set_hit = bus.set_en && (bus.set_addr != '0);

  always_comb begin
    regs_d = regs_q;
    if (wr_hit) regs_d[bus.wr_addr] = bus.wr_data;
    regs_d[0] = '0;
  end

  // A newer producer (set) outranks the retiring write; flush outranks both.
  always_comb begin
    busy_d = busy_q;
    if (wr_hit)    busy_d[bus.wr_addr]  = 1'b0;
    if (set_hit)   busy_d[bus.set_addr] = 1'b1;
    if (bus.flush) busy_d = '0;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int r = 0; r < REG_QUAN; r++) regs_q[r] <= '0;
      busy_q <= '0;
    end else begin
      regs_q <= regs_d;
      busy_q <= busy_d;
    end
  end

  // Forwarding is gated by rstn so outputs stay zero while reset is held.
  for (genvar i = 0; i < RD_PORTS; i++) begin : g_rd
    logic [AW-1:0] ra;
    logic          fwd;

    assign ra  = bus.rd_addr[i*AW +: AW];
    assign fwd = (BYPASS != 0) && rstn && wr_hit && (bus.wr_addr == ra);

    assign bus.rd_data[i*CPU_WIDTH +: CPU_WIDTH] =
      (ra == '0) ? '0 : (fwd ? bus.wr_data : regs_q[ra]);
    assign bus.rd_busy[i] =
      (fwd && !(set_hit && (bus.set_addr == ra))) ? 1'b0 : busy_q[ra];
  end
endmodule

// File: tb/tb_regfile_sb.sv
// Scoreboard bench for regfile_sb: two instances (forwarding on/off) share stimulus;
// the driver queues expected read results and a monitor pops and compares them.
module tb_regfile_sb;
  logic clk;
  logic rstn;

  regfile_sb_if #(.CPU_WIDTH(32), .REG_QUAN(32), .RD_PORTS(2)) bus_b1 ();
  regfile_sb_if #(.CPU_WIDTH(32), .REG_QUAN(32), .RD_PORTS(2)) bus_b0 ();

  regfile_sb #(.CPU_WIDTH(32), .REG_QUAN(32), .RD_PORTS(2), .BYPASS(1)) dut_b1 (
    .clk (clk),
    .rstn(rstn),
    .bus (bus_b1)
  );

  regfile_sb #(.CPU_WIDTH(32), .REG_QUAN(32), .RD_PORTS(2), .BYPASS(0)) dut_b0 (
    .clk (clk),
    .rstn(rstn),
    .bus (bus_b0)
  );

  assign bus_b0.rd_addr  = bus_b1.rd_addr;
  assign bus_b0.wr_en    = bus_b1.wr_en;
  assign bus_b0.wr_addr  = bus_b1.wr_addr;
  assign bus_b0.wr_data  = bus_b1.wr_data;
  assign bus_b0.set_en   = bus_b1.set_en;
  assign bus_b0.set_addr = bus_b1.set_addr;
  assign bus_b0.flush    = bus_b1.flush;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          dut;
    int          port;
    logic [31:0] data;
    logic        busy;
    string       name;
  } exp_t;

  exp_t q[$];
  int   n_vec;
  int   n_err;
  event ev_chk;

  task automatic drive(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                       input logic se, input logic [4:0] sa, input logic fl,
                       input logic [4:0] r0, input logic [4:0] r1);
    @(negedge clk);
    bus_b1.wr_en    = we;
    bus_b1.wr_addr  = wa;
    bus_b1.wr_data  = wd;
    bus_b1.set_en   = se;
    bus_b1.set_addr = sa;
    bus_b1.flush    = fl;
    bus_b1.rd_addr  = {r1, r0};
  endtask

  task automatic ex(input int d, input int p, input logic [31:0] dt, input logic b,
                    input string nm);
    exp_t e;
    e.dut  = d;
    e.port = p;
    e.data = dt;
    e.busy = b;
    e.name = nm;
    q.push_back(e);
  endtask

  task automatic fire();
    -> ev_chk;
  endtask

  initial begin
    exp_t        e;
    logic [31:0] act_d;
    logic        act_b;
    forever begin
      @(ev_chk);
      #1;
      while (q.size() > 0) begin
        e = q.pop_front();
        if (e.dut == 1) begin
          act_d = bus_b1.rd_data[e.port*32 +: 32];
          act_b = bus_b1.rd_busy[e.port];
        end else begin
          act_d = bus_b0.rd_data[e.port*32 +: 32];
          act_b = bus_b0.rd_busy[e.port];
        end
        n_vec++;
        if (act_d !== e.data || act_b !== e.busy) begin
          n_err++;
          $display("FAIL %s (bypass=%0d port%0d): got data=%h busy=%b, want data=%h busy=%b",
                   e.name, e.dut, e.port, act_d, act_b, e.data, e.busy);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    n_vec = 0;
    n_err = 0;
    rstn  = 1'b0;
    bus_b1.wr_en    = 1'b0;
    bus_b1.wr_addr  = '0;
    bus_b1.wr_data  = '0;
    bus_b1.set_en   = 1'b0;
    bus_b1.set_addr = '0;
    bus_b1.flush    = 1'b0;
    bus_b1.rd_addr  = '0;

    // Held in reset with an active write that would otherwise forward.
    drive(1'b1, 5'd5, 32'h0000_FFFF, 1'b1, 5'd5, 1'b0, 5'd5, 5'd5);
    ex(1, 0, 32'h0, 1'b0, "rst_fwd_gated_p0");
    ex(1, 1, 32'h0, 1'b0, "rst_fwd_gated_p1");
    ex(0, 0, 32'h0, 1'b0, "rst_nobyp_p0");
    fire();
    #2;
    rstn = 1'b1;
    bus_b1.wr_en  = 1'b0;
    bus_b1.set_en = 1'b0;

    for (int a = 0; a < 32; a++) begin
      drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 5'(a), 5'(31 - a));
      ex(1, 0, 32'h0, 1'b0, "reset_sweep_p0");
      ex(1, 1, 32'h0, 1'b0, "reset_sweep_p1");
      fire();
    end

    drive(1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0, 5'd0, 1'b0, 5'd5, 5'd0);
    ex(1, 0, 32'hDEAD_BEEF, 1'b0, "fwd_x5");
    ex(0, 0, 32'h0, 1'b0, "nofwd_x5_old");
    fire();
    drive(1'b1, 5'd0, 32'h0000_1234, 1'b0, 5'd0, 1'b0, 5'd0, 5'd5);
    ex(1, 0, 32'h0, 1'b0, "x0_no_fwd");
    ex(1, 1, 32'hDEAD_BEEF, 1'b0, "x5_stored_p1");
    ex(0, 1, 32'hDEAD_BEEF, 1'b0, "x5_stored_p1_nobyp");
    fire();
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd0, 5'd0);
    ex(1, 0, 32'h0, 1'b0, "x0_after_write");
    ex(0, 1, 32'h0, 1'b0, "x0_after_write_nobyp");
    fire();

    drive(1'b1, 5'd7, 32'h55, 1'b0, 5'd0, 1'b0, 5'd7, 5'd7);
    ex(1, 0, 32'h55, 1'b0, "fwd_x7_p0");
    ex(1, 1, 32'h55, 1'b0, "fwd_x7_p1");
    ex(0, 0, 32'h0, 1'b0, "nofwd_x7_old");
    fire();

    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 1'b0, 5'd3, 5'd7);
    ex(1, 0, 32'h0, 1'b0, "set_x3_not_yet_busy");
    ex(1, 1, 32'h55, 1'b0, "x7_stored");
    ex(0, 1, 32'h55, 1'b0, "x7_stored_nobyp");
    fire();
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd7, 5'd3);
    ex(1, 1, 32'h0, 1'b1, "busy_x3");
    ex(0, 1, 32'h0, 1'b1, "busy_x3_nobyp");
    fire();
    drive(1'b1, 5'd3, 32'h9, 1'b0, 5'd0, 1'b0, 5'd3, 5'd3);
    ex(1, 0, 32'h9, 1'b0, "wr_x3_fwd_p0");
    ex(1, 1, 32'h9, 1'b0, "wr_x3_fwd_p1");
    ex(0, 0, 32'h0, 1'b1, "wr_x3_nofwd");
    fire();
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd3, 5'd3);
    ex(1, 0, 32'h9, 1'b0, "x3_cleared");
    ex(0, 0, 32'h9, 1'b0, "x3_cleared_nobyp");
    fire();
    drive(1'b1, 5'd3, 32'h10, 1'b1, 5'd3, 1'b0, 5'd3, 5'd0);
    ex(1, 0, 32'h10, 1'b0, "setwr_x3_same_cycle");
    ex(0, 0, 32'h9, 1'b0, "setwr_x3_same_nobyp");
    fire();
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd3, 5'd3);
    ex(1, 0, 32'h10, 1'b1, "setwr_busy_kept_p0");
    ex(1, 1, 32'h10, 1'b1, "setwr_busy_kept_p1");
    ex(0, 0, 32'h10, 1'b1, "setwr_busy_kept_nobyp");
    fire();

    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd4, 1'b0, 5'd4, 5'd0);
    ex(1, 0, 32'h0, 1'b0, "set_x4_not_yet");
    fire();
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd6, 1'b0, 5'd4, 5'd3);
    ex(1, 0, 32'h0, 1'b1, "busy_x4");
    ex(1, 1, 32'h10, 1'b1, "busy_x3_still");
    fire();
    drive(1'b1, 5'd9, 32'h77, 1'b1, 5'd8, 1'b1, 5'd6, 5'd4);
    ex(1, 0, 32'h0, 1'b1, "busy_x6_pre_flush");
    ex(1, 1, 32'h0, 1'b1, "busy_x4_pre_flush");
    fire();
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd8, 5'd6);
    ex(1, 0, 32'h0, 1'b0, "flush_beats_set_x8");
    ex(1, 1, 32'h0, 1'b0, "flush_x6");
    ex(0, 0, 32'h0, 1'b0, "flush_x8_nobyp");
    fire();
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd4, 5'd9);
    ex(1, 0, 32'h0, 1'b0, "flush_x4");
    ex(1, 1, 32'h77, 1'b0, "flush_keeps_write_x9");
    fire();

    drive(1'b1, 5'd2, 32'hA, 1'b1, 5'd3, 1'b0, 5'd0, 5'd0);
    ex(1, 0, 32'h0, 1'b0, "x0_zero");
    fire();
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd2, 5'd3);
    ex(1, 0, 32'hA, 1'b0, "x2_stored");
    ex(1, 1, 32'h10, 1'b1, "x3_busy_pre_rst");
    fire();
    drive(1'b1, 5'd2, 32'hFF, 1'b1, 5'd4, 1'b0, 5'd2, 5'd3);
    rstn = 1'b0;
    ex(1, 0, 32'h0, 1'b0, "midrst_x2");
    ex(1, 1, 32'h0, 1'b0, "midrst_x3_busy");
    ex(0, 0, 32'h0, 1'b0, "midrst_x2_nobyp");
    fire();
    @(posedge clk);
    #2;
    rstn = 1'b1;
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd2, 5'd4);
    ex(1, 0, 32'h0, 1'b0, "post_rst_x2_discarded");
    ex(1, 1, 32'h0, 1'b0, "post_rst_x4_not_set");
    fire();
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd5, 5'd7);
    ex(1, 0, 32'h0, 1'b0, "post_rst_x5");
    ex(0, 1, 32'h0, 1'b0, "post_rst_x7_nobyp");
    fire();

    @(negedge clk);
    if (q.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain: %0d entries left, want 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
